// File: rtl/riscv_core_dpath_vec_alu_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : riscv_core_dpath_vec_alu_seq
// Description : Multi-cycle vector ALU for the X stage of the vector datapath.
//               Accepts one op per handshake, computes LANES elements per beat
//               and returns the element-wise result plus a scalar reduction.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module riscv_core_dpath_vec_alu_seq #(
    parameter int NELEM = 8,
    parameter int EW    = 32,
    parameter int LANES = 2,
    parameter int VLW   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_val,
    output logic                req_rdy,
    input  logic [3:0]          req_fn,
    input  logic [VLW-1:0]      req_vl,
    input  logic [NELEM*EW-1:0] req_vin0,
    input  logic [NELEM*EW-1:0] req_vin1,
    input  logic [EW-1:0]       req_in0,
    input  logic                req_in0_ven,
    input  logic [EW-1:0]       req_in1,
    input  logic                req_in1_ven,
    output logic                resp_val,
    input  logic                resp_rdy,
    output logic [NELEM*EW-1:0] resp_vout,
    output logic [EW-1:0]       resp_out
);

    localparam int             c_IW     = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam logic [VLW-1:0] c_VL_MAX = VLW'(NELEM - 1);

    localparam logic [3:0] c_FN_ADD = 4'd0;
    localparam logic [3:0] c_FN_SUB = 4'd1;
    localparam logic [3:0] c_FN_SLT = 4'd4;
    localparam logic [3:0] c_FN_SEQ = 4'd12;
    localparam logic [3:0] c_FN_RED = 4'd8;

    // FIN is a one-cycle finalisation step between the last beat and DONE
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_FIN  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [VLW-1:0] r_beat;
    logic [VLW-1:0] r_vl_eff;
    logic [3:0]     r_fn;
    logic [EW-1:0]  r_a    [NELEM];
    logic [EW-1:0]  r_b    [NELEM];
    logic [EW-1:0]  r_vout [NELEM];
    logic [EW-1:0]  r_acc;
    logic [EW-1:0]  r_out;

    logic           w_accept;
    logic           w_last_beat;
    logic           w_fn_ok;
    logic [31:0]    w_lane_pos  [LANES];
    logic [c_IW-1:0] w_lane_idx [LANES];
    logic           w_lane_act  [LANES];
    logic [EW-1:0]  w_lane_a    [LANES];
    logic [EW-1:0]  w_lane_b    [LANES];
    logic [EW-1:0]  w_lane_diff [LANES];
    logic [EW-1:0]  w_lane_res  [LANES];
    logic [EW-1:0]  w_acc_nxt;

    assign w_accept    = (r_state == c_ST_IDLE) && req_val;
    assign w_last_beat = (r_beat == VLW'(32'(r_vl_eff) / 32'(LANES)));
    assign w_fn_ok     = (r_fn == c_FN_ADD) || (r_fn == c_FN_SUB) || (r_fn == c_FN_SLT) ||
                         (r_fn == c_FN_SEQ) || (r_fn == c_FN_RED);

    // Per-lane element results for the current beat and the running reduction
    always_comb begin
        w_acc_nxt = r_acc;
        for (int l = 0; l < LANES; l++) begin
            w_lane_pos[l]  = 32'(r_beat) * 32'(LANES) + 32'(l);
            w_lane_idx[l]  = w_lane_pos[l][c_IW-1:0];
            w_lane_act[l]  = (w_lane_pos[l] <= 32'(r_vl_eff));
            w_lane_a[l]    = r_a[w_lane_idx[l]];
            w_lane_b[l]    = r_b[w_lane_idx[l]];
            w_lane_diff[l] = w_lane_a[l] - w_lane_b[l];
            w_lane_res[l]  = '0;
            case (r_fn)
                c_FN_ADD: w_lane_res[l] = w_lane_a[l] + w_lane_b[l];
                c_FN_SUB: w_lane_res[l] = w_lane_diff[l];
                // Signed less-than: operands of differing sign decide on a's sign,
                // otherwise the difference cannot overflow and its sign decides.
                c_FN_SLT: w_lane_res[l] = EW'((w_lane_a[l][EW-1] != w_lane_b[l][EW-1]) ?
                                              w_lane_a[l][EW-1] : w_lane_diff[l][EW-1]);
                c_FN_SEQ: w_lane_res[l] = EW'(w_lane_a[l] == w_lane_b[l]);
                c_FN_RED: w_lane_res[l] = w_lane_a[l];
                default:  w_lane_res[l] = '0;
            endcase
            if (!w_lane_act[l]) begin
                w_lane_res[l] = '0;
            end
            if (w_lane_act[l] && (r_fn == c_FN_RED)) begin
                w_acc_nxt = w_acc_nxt + w_lane_a[l];
            end
        end
    end

    // Next-state logic of the op sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (req_val)     w_state_nxt = c_ST_BUSY;
            c_ST_BUSY: if (w_last_beat) w_state_nxt = c_ST_FIN;
            c_ST_FIN:                   w_state_nxt = c_ST_DONE;
            c_ST_DONE: if (resp_rdy)    w_state_nxt = c_ST_IDLE;
            default:                    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Operand capture at the accept edge; scalars are broadcast when not vector-enabled
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < NELEM; i++) begin
                r_a[i] <= req_in0_ven ? req_vin0[i*EW +: EW] : req_in0;
                r_b[i] <= req_in1_ven ? req_vin1[i*EW +: EW] : req_in1;
            end
        end
    end

    // Control state, beat counter, result vector, accumulator and scalar result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_beat   <= '0;
            r_vl_eff <= '0;
            r_fn     <= '0;
            r_acc    <= '0;
            r_out    <= '0;
            for (int i = 0; i < NELEM; i++) begin
                r_vout[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_beat   <= '0;
                r_vl_eff <= (req_vl > c_VL_MAX) ? c_VL_MAX : req_vl;
                r_fn     <= req_fn;
                r_acc    <= '0;
                r_out    <= '0;
                for (int i = 0; i < NELEM; i++) begin
                    r_vout[i] <= '0;
                end
            end else if (r_state == c_ST_BUSY) begin
                r_beat <= r_beat + 1'b1;
                r_acc  <= w_acc_nxt;
                for (int l = 0; l < LANES; l++) begin
                    r_vout[w_lane_idx[l]] <= w_lane_res[l];
                end
            end else if (r_state == c_ST_FIN) begin
                if (r_fn == c_FN_RED) begin
                    r_out <= r_acc;
                end else if (w_fn_ok) begin
                    r_out <= r_a[0];
                end else begin
                    r_out <= '0;
                end
            end
        end
    end

    assign req_rdy  = (r_state == c_ST_IDLE);
    assign resp_val = (r_state == c_ST_DONE);
    assign resp_out = r_out;

    generate
        for (genvar g = 0; g < NELEM; g++) begin : g_pack
            assign resp_vout[g*EW +: EW] = r_vout[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_dpath_vec_alu_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_riscv_core_dpath_vec_alu_seq
// Description : Self-checking bench for the multi-cycle vector ALU with a
//               behavioural reference model and randomized operands.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_riscv_core_dpath_vec_alu_seq;

    localparam int NELEM = 8;
    localparam int EW    = 32;
    localparam int LANES = 2;
    localparam int VLW   = 4;
    localparam int VW    = NELEM * EW;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_val;
    logic          req_rdy;
    logic [3:0]    req_fn;
    logic [VLW-1:0] req_vl;
    logic [VW-1:0] req_vin0;
    logic [VW-1:0] req_vin1;
    logic [EW-1:0] req_in0;
    logic          req_in0_ven;
    logic [EW-1:0] req_in1;
    logic          req_in1_ven;
    logic          resp_val;
    logic          resp_rdy;
    logic [VW-1:0] resp_vout;
    logic [EW-1:0] resp_out;

    int vectors    = 0;
    int miscompares = 0;

    riscv_core_dpath_vec_alu_seq #(
        .NELEM(NELEM), .EW(EW), .LANES(LANES), .VLW(VLW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_fn      (req_fn),
        .req_vl      (req_vl),
        .req_vin0    (req_vin0),
        .req_vin1    (req_vin1),
        .req_in0     (req_in0),
        .req_in0_ven (req_in0_ven),
        .req_in1     (req_in1),
        .req_in1_ven (req_in1_ven),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_vout   (resp_vout),
        .resp_out    (resp_out)
    );

    always #5 clk = ~clk;

    // Reference model: element-wise semantics straight from the operation table
    function automatic void model(input logic [3:0] fn, input logic [VLW-1:0] vl,
                                  input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                                  input logic [EW-1:0] s0, input logic [EW-1:0] s1,
                                  input logic e0, input logic e1,
                                  output logic [VW-1:0] vout, output logic [EW-1:0] out,
                                  output int lat);
        int vle;
        logic [EW-1:0] a, b, a0, sum;
        vle  = (int'(vl) > NELEM - 1) ? NELEM - 1 : int'(vl);
        vout = '0;
        sum  = '0;
        a0   = e0 ? v0[EW-1:0] : s0;
        for (int i = 0; i < NELEM; i++) begin
            a = e0 ? v0[i*EW +: EW] : s0;
            b = e1 ? v1[i*EW +: EW] : s1;
            if (i <= vle) begin
                case (fn)
                    4'd0:  vout[i*EW +: EW] = a + b;
                    4'd1:  vout[i*EW +: EW] = a - b;
                    4'd4:  vout[i*EW +: EW] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    4'd12: vout[i*EW +: EW] = (a == b) ? 32'd1 : 32'd0;
                    4'd8:  begin vout[i*EW +: EW] = a; sum = sum + a; end
                    default: vout[i*EW +: EW] = '0;
                endcase
            end
        end
        if (fn == 4'd8)
            out = sum;
        else if (fn == 4'd0 || fn == 4'd1 || fn == 4'd4 || fn == 4'd12)
            out = a0;
        else
            out = '0;
        lat = vle / LANES + 2;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < NELEM; i++) v[i*EW +: EW] = $urandom;
        return v;
    endfunction

    task automatic scramble_inputs();
        req_fn      = 4'($urandom);
        req_vl      = VLW'($urandom);
        req_vin0    = rand_vec();
        req_vin1    = rand_vec();
        req_in0     = $urandom;
        req_in1     = $urandom;
        req_in0_ven = 1'($urandom);
        req_in1_ven = 1'($urandom);
    endtask

    // Issue one op, disturb the inputs after acceptance, wait for and consume the response
    task automatic do_op(input logic [3:0] fn, input logic [VLW-1:0] vl,
                         input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                         input logic [EW-1:0] s0, input logic [EW-1:0] s1,
                         input logic e0, input logic e1,
                         output int lat, output logic [VW-1:0] vo, output logic [EW-1:0] o);
        int guard = 0;
        req_fn = fn; req_vl = vl; req_vin0 = v0; req_vin1 = v1;
        req_in0 = s0; req_in1 = s1; req_in0_ven = e0; req_in1_ven = e1;
        req_val = 1'b1;
        resp_rdy = 1'b1;
        while (!req_rdy && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        req_val = 1'b0;
        scramble_inputs();
        lat = 0;
        while (!resp_val && lat < 100) begin @(posedge clk); #1; lat++; end
        vo = resp_vout;
        o  = resp_out;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_val = 1'b0; resp_rdy = 1'b0;
        scramble_inputs();
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({req_rdy, resp_val} !== 2'b10 || resp_vout !== '0 || resp_out !== '0) begin
            miscompares++;
            $display("FAIL reset: rdy/val=%b vout=%h out=%h, required rdy/val=10 vout=0 out=0",
                     {req_rdy, resp_val}, resp_vout, resp_out);
        end
    endtask

    task automatic test_add();
        logic [VW-1:0] v0, v1, vo, exp_v;
        logic [EW-1:0] o;
        int lat;
        for (int i = 0; i < NELEM; i++) begin
            v0[i*EW +: EW] = i;
            v1[i*EW +: EW] = 10 * i;
            exp_v[i*EW +: EW] = 11 * i;
        end
        do_op(4'd0, 4'd7, v0, v1, $urandom, $urandom, 1'b1, 1'b1, lat, vo, o);
        vectors++;
        if (vo !== exp_v) begin
            miscompares++;
            $display("FAIL add_vout: got %h, required %h", vo, exp_v);
        end
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL add_latency: got %0d, required 5", lat);
        end
        vectors++;
        if (o !== 32'd0) begin
            miscompares++;
            $display("FAIL add_out: got %h, required 0", o);
        end
    endtask

    task automatic test_sub_broadcast();
        logic [VW-1:0] v0, vo, exp_v;
        logic [EW-1:0] o;
        int lat;
        for (int i = 0; i < NELEM; i++) begin
            v0[i*EW +: EW] = 100;
            exp_v[i*EW +: EW] = (i <= 3) ? 32'd99 : 32'd0;
        end
        do_op(4'd1, 4'd3, v0, rand_vec(), $urandom, 32'd1, 1'b1, 1'b0, lat, vo, o);
        vectors++;
        if (vo !== exp_v) begin
            miscompares++;
            $display("FAIL sub_bcast_vout: got %h, required %h", vo, exp_v);
        end
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL sub_bcast_latency: got %0d, required 3", lat);
        end
    endtask

    task automatic test_compare();
        logic [VW-1:0] v0, v1, vo;
        logic [EW-1:0] o;
        int lat;
        v0 = rand_vec(); v1 = rand_vec();
        v0[0*EW +: EW] = 32'h8000_0000; v1[0*EW +: EW] = 32'd1;
        v0[1*EW +: EW] = 32'd5;         v1[1*EW +: EW] = 32'hFFFF_FFFF;
        v0[2*EW +: EW] = 32'd7;         v1[2*EW +: EW] = 32'd7;
        do_op(4'd4, 4'd2, v0, v1, $urandom, $urandom, 1'b1, 1'b1, lat, vo, o);
        vectors++;
        if (vo[3*EW-1:0] !== {32'd0, 32'd0, 32'd1} || vo[VW-1:3*EW] !== '0) begin
            miscompares++;
            $display("FAIL slt_vout: got %h, required elems0..2=1,0,0 rest 0", vo);
        end
        vectors++;
        if (o !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL slt_out: got %h, required 80000000", o);
        end
        do_op(4'd12, 4'd0, v0, v1, $urandom, $urandom, 1'b0, 1'b0, lat, vo, o);
        do_op(4'd12, 4'd1, v0, v1, 32'd7, 32'd7, 1'b0, 1'b0, lat, vo, o);
        vectors++;
        if (vo[2*EW-1:0] !== {32'd1, 32'd1} || vo[VW-1:2*EW] !== '0) begin
            miscompares++;
            $display("FAIL seq_vout: got %h, required elems0..1=1 rest 0", vo);
        end
    endtask

    task automatic test_redsum();
        logic [VW-1:0] v0, vo;
        logic [EW-1:0] o;
        int lat;
        v0 = '1;
        do_op(4'd8, 4'd7, v0, rand_vec(), $urandom, $urandom, 1'b1, 1'b1, lat, vo, o);
        vectors++;
        if (o !== 32'hFFFF_FFF8 || vo !== v0) begin
            miscompares++;
            $display("FAIL redsum_wrap: out=%h vout=%h, required out=fffffff8 vout=all ones", o, vo);
        end
        v0 = rand_vec();
        v0[EW-1:0] = 32'd42;
        do_op(4'd8, 4'd0, v0, rand_vec(), $urandom, $urandom, 1'b1, 1'b1, lat, vo, o);
        vectors++;
        if (o !== 32'd42 || vo !== {{(VW-EW){1'b0}}, 32'd42}) begin
            miscompares++;
            $display("FAIL redsum_vl0: out=%h vout=%h, required out=42 vout=elem0 42", o, vo);
        end
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL redsum_vl0_latency: got %0d, required 2", lat);
        end
    endtask

    task automatic test_random();
        logic [3:0] fn;
        logic [VLW-1:0] vl;
        logic [VW-1:0] v0, v1, vo, exp_v;
        logic [EW-1:0] s0, s1, o, exp_o;
        logic e0, e1;
        int lat, exp_lat;
        logic [3:0] fns [6] = '{4'd0, 4'd1, 4'd4, 4'd12, 4'd8, 4'd0};
        for (int n = 0; n < 40; n++) begin
            fns[5] = 4'($urandom);
            fn = fns[$urandom_range(0, 5)];
            vl = VLW'($urandom);
            v0 = rand_vec(); v1 = rand_vec();
            s0 = $urandom;   s1 = $urandom;
            e0 = 1'($urandom); e1 = 1'($urandom);
            if (n % 4 == 0) v1 = v0;
            model(fn, vl, v0, v1, s0, s1, e0, e1, exp_v, exp_o, exp_lat);
            do_op(fn, vl, v0, v1, s0, s1, e0, e1, lat, vo, o);
            vectors++;
            if (vo !== exp_v || o !== exp_o || lat !== exp_lat) begin
                miscompares++;
                $display("FAIL random fn=%0d vl=%0d: vout=%h out=%h lat=%0d, required vout=%h out=%h lat=%0d",
                         fn, vl, vo, o, lat, exp_v, exp_o, exp_lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] v0, v1, w0, w1, vo, held_v, exp_v;
        logic [EW-1:0] o, held_o, exp_o;
        int lat, exp_lat, guard;
        v0 = rand_vec(); v1 = rand_vec();
        w0 = rand_vec(); w1 = rand_vec();
        req_fn = 4'd1; req_vl = 4'd5; req_vin0 = v0; req_vin1 = v1;
        req_in0_ven = 1'b1; req_in1_ven = 1'b1;
        req_val = 1'b1; resp_rdy = 1'b0;
        @(posedge clk); #1;
        // second request is presented and held while the first is in flight
        req_fn = 4'd0; req_vl = 4'd6; req_vin0 = w0; req_vin1 = w1;
        guard = 0;
        while (!resp_val && guard < 100) begin @(posedge clk); #1; guard++; end
        held_v = resp_vout; held_o = resp_out;
        model(4'd1, 4'd5, v0, v1, '0, '0, 1'b1, 1'b1, exp_v, exp_o, exp_lat);
        vectors++;
        if (held_v !== exp_v || held_o !== exp_o) begin
            miscompares++;
            $display("FAIL bp_first_result: vout=%h out=%h, required vout=%h out=%h",
                     held_v, held_o, exp_v, exp_o);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (resp_val !== 1'b1 || req_rdy !== 1'b0 || resp_vout !== held_v || resp_out !== held_o) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: val=%b rdy=%b vout=%h out=%h, required val=1 rdy=0 stable",
                         c, resp_val, req_rdy, resp_vout, resp_out);
            end
        end
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: val=%b rdy=%b, required val=0 rdy=1", resp_val, req_rdy);
        end
        @(posedge clk); #1;
        req_val = 1'b0;
        scramble_inputs();
        vectors++;
        if (req_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_second_accept: rdy=%b, required 0", req_rdy);
        end
        lat = 0;
        while (!resp_val && lat < 100) begin @(posedge clk); #1; lat++; end
        vo = resp_vout; o = resp_out;
        model(4'd0, 4'd6, w0, w1, '0, '0, 1'b1, 1'b1, exp_v, exp_o, exp_lat);
        vectors++;
        if (vo !== exp_v || o !== exp_o || lat !== exp_lat) begin
            miscompares++;
            $display("FAIL bp_second_result: vout=%h out=%h lat=%0d, required vout=%h out=%h lat=%0d",
                     vo, o, lat, exp_v, exp_o, exp_lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        logic [VW-1:0] v0, v1, vo, exp_v;
        logic [EW-1:0] o, exp_o;
        int lat, exp_lat;
        bit seen;
        req_fn = 4'd0; req_vl = 4'd7; req_vin0 = rand_vec(); req_vin1 = rand_vec();
        req_in0_ven = 1'b1; req_in1_ven = 1'b1;
        req_val = 1'b1; resp_rdy = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1 || resp_vout !== '0 || resp_out !== '0) begin
            miscompares++;
            $display("FAIL reset_midop: val=%b rdy=%b vout=%h out=%h, required val=0 rdy=1 vout=0 out=0",
                     resp_val, req_rdy, resp_vout, resp_out);
        end
        @(posedge clk); #3 reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (resp_val) seen = 1'b1; end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dropped_op: resp_val seen=%b, required 0", seen);
        end
        v0 = rand_vec(); v1 = rand_vec();
        model(4'd1, 4'd7, v0, v1, '0, '0, 1'b1, 1'b1, exp_v, exp_o, exp_lat);
        do_op(4'd1, 4'd7, v0, v1, '0, '0, 1'b1, 1'b1, lat, vo, o);
        vectors++;
        if (vo !== exp_v || o !== exp_o || lat !== exp_lat) begin
            miscompares++;
            $display("FAIL reset_followup: vout=%h out=%h lat=%0d, required vout=%h out=%h lat=%0d",
                     vo, o, lat, exp_v, exp_o, exp_lat);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_broadcast();
        test_compare();
        test_redsum();
        test_random();
        test_backpressure();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
